sync_flag_fifo: RTL and testbench
=================================

Name: sync_flag_fifo

Overview:
Single-clock FIFO that responds to the test-side `inf` driver: it accepts `wr_en`/`data_in` writes and `rd_en` reads. It returns `data_out` plus the status set `wr_ack`, `overflow`, `underflow`, `almostempty`, `empty`, `almostfull`, `full` and `half_full`. It is the DUT end of that interface and binds to its DUT modport.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of entries; must be a power of 2, at least 4.
- ALMOST_MARGIN, 1, distance from empty/full at which the almost flags assert; must be at least 1 and less than FIFO_DEPTH/2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data, registered.
- wr_ack  output  1  registered pulse: previous-cycle write accepted.
- overflow  output  1  registered pulse: previous-cycle write rejected.
- underflow  output  1  registered pulse: previous-cycle read rejected.
- almostempty  output  1  count == ALMOST_MARGIN.
- empty  output  1  count == 0.
- almostfull  output  1  count == FIFO_DEPTH-ALMOST_MARGIN.
- full  output  1  count == FIFO_DEPTH.
- half_full  output  1  count >= FIFO_DEPTH/2.

Behaviour:
- State:
  - `wr_ptr` and `rd_ptr`, each clog2(FIFO_DEPTH) bits, wrap naturally from DEPTH-1 to 0.
  - `count`, clog2(FIFO_DEPTH)+1 bits.
  - Storage array of FIFO_DEPTH x FIFO_WIDTH.
- Reset (rst_n=0 at posedge):
  - Pointers and count go to 0; data_out=0; wr_ack, overflow, underflow go to 0.
  - Storage contents are don't-care.
  - Reset has priority over wr_en/rd_en in the same cycle; a request in that cycle is dropped with no ack and no error pulse.
- Derived flags:
  - Combinational from count, so they reflect the post-edge count.
  - After reset: empty=1; all other flags 0.
- Write acceptance:
  - A write is accepted when wr_en=1 and count<FIFO_DEPTH.
  - On acceptance: mem[wr_ptr] <= data_in, wr_ptr increments, and next cycle wr_ack=1, overflow=0.
- Write rejection:
  - wr_en=1 with full=1: storage is unchanged, next cycle overflow=1, wr_ack=0.
- Read acceptance:
  - A read is accepted when rd_en=1 and count>0.
  - On acceptance: data_out <= mem[rd_ptr] (one-cycle latency), rd_ptr increments, next cycle underflow=0.
- Read rejection:
  - rd_en=1 with empty=1: data_out holds its previous value, next cycle underflow=1.
- Idle:
  - wr_ack, overflow and underflow deassert the cycle after their request is removed; data_out holds.
- Simultaneous wr_en=1 and rd_en=1:
  - 0<count<FIFO_DEPTH: both accepted, count unchanged, both pointers advance.
  - count==0: write accepted (wr_ack=1), read rejected (underflow=1), count becomes 1; no read-through.
  - count==FIFO_DEPTH: read accepted, write rejected (overflow=1), count becomes DEPTH-1. The macro below changes this case.
- Count update: count <= count + accepted_write - accepted_read. It never leaves the range [0, FIFO_DEPTH].
- Wrap-around: the pointer roll-over from DEPTH-1 to 0 must not disturb count or the flags.

Optional Feature:
- Macro: FIFO_FULL_RW_EN.
- Defined: in the full case with wr_en=1 and rd_en=1, both are accepted.
  - data_out receives the oldest entry.
  - data_in is written into the slot being vacated.
  - count stays at FIFO_DEPTH; full stays 1; wr_ack=1 and overflow=0.
- Undefined: behaviour is exactly as in Behaviour above (write rejected, overflow=1).

Test Plan:
1. Reset then idle (rst_n=0 for 1 cycle, then 1): empty=1, full=0, half_full=0, data_out=0x0000, wr_ack=0, overflow=0, underflow=0.
2. Read when empty: read 1 cycle -> underflow=1 for one cycle, data_out stays 0x0000, count stays 0.
3. Fill and overflow:
   - Write 0x0001..0x0008 -> wr_ack=1 each cycle.
   - half_full asserts after the 4th write, almostfull after the 7th, full after the 8th.
   - A 9th write of 0xDEAD -> overflow=1, wr_ack=0.
4. Drain with wrap:
   - Read 8 times -> data_out = 0x0001..0x0008 in order, 1 cycle after each rd_en.
   - almostempty=1 after the 7th read, empty=1 after the 8th.
   - Then write 0x00AA and read -> 0x00AA, exercising pointer wrap.
5. Simultaneous requests with count=3: wr_en=rd_en=1, data_in=0x0055 -> count stays 3, wr_ack=1, data_out = oldest entry.
6. Boundary cases:
   - Full with wr_en=rd_en=1: macro undefined -> overflow=1 and count=7; macro defined -> count=8, wr_ack=1.
   - Reset asserted alongside wr_en=1 at count=5 -> count=0, wr_ack=0 next cycle.

Source files
------------

// File: rtl/sync_flag_fifo_if.sv
// Handshake/status bundle between the FIFO driver (master) and the sync_flag_fifo DUT (slave).
interface sync_flag_fifo_if #(
    parameter int unsigned FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  almostempty;
    logic                  empty;
    logic                  almostfull;
    logic                  full;
    logic                  half_full;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
               almostempty, empty, almostfull, full, half_full
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
               almostempty, empty, almostfull, full, half_full
    );
endinterface

// File: rtl/sync_flag_fifo.sv
// Single-clock FIFO with registered read data, ack/error pulses and count-decoded status flags.
// Optional FIFO_FULL_RW_EN: accept a simultaneous write+read while full (write lands in the vacated slot).
module sync_flag_fifo #(
    parameter int unsigned FIFO_WIDTH    = 16,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned ALMOST_MARGIN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sync_flag_fifo_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_ok_c;
    logic                  rd_ok_c;
    logic                  full_c;
    logic                  empty_c;

    assign full_c  = (count == CNT_W'(FIFO_DEPTH));
    assign empty_c = (count == '0);

    // Acceptance decisions for this cycle's requests
    always_comb begin
        rd_ok_c = bus.rd_en && !empty_c;
`ifdef FIFO_FULL_RW_EN
        wr_ok_c = bus.wr_en && (!full_c || bus.rd_en);
`else
        wr_ok_c = bus.wr_en && !full_c;
`endif
    end

    // Pointers, occupancy, read data and handshake pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_ok_c;
            overflow  <= bus.wr_en && !wr_ok_c;
            underflow <= bus.rd_en && !rd_ok_c;
            if (wr_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok_c) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                data_out <= mem[rd_ptr];
            end
            count <= count + CNT_W'(wr_ok_c) - CNT_W'(rd_ok_c);
        end
    end

    // Storage has no reset; a write during reset is dropped
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok_c) mem[wr_ptr] <= bus.data_in;
    end

    assign bus.data_out    = data_out;
    assign bus.wr_ack      = wr_ack;
    assign bus.overflow    = overflow;
    assign bus.underflow   = underflow;
    assign bus.empty       = empty_c;
    assign bus.full        = full_c;
    assign bus.almostempty = (count == CNT_W'(ALMOST_MARGIN));
    assign bus.almostfull  = (count == CNT_W'(FIFO_DEPTH - ALMOST_MARGIN));
    assign bus.half_full   = (count >= CNT_W'(FIFO_DEPTH / 2));
endmodule

// File: tb/tb_sync_flag_fifo.sv
// Directed self-checking bench for sync_flag_fifo (default 16x8, margin 1).
module tb_sync_flag_fifo;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sync_flag_fifo_if #(.FIFO_WIDTH(16)) bus ();

    sync_flag_fifo #(
        .FIFO_WIDTH(16),
        .FIFO_DEPTH(8),
        .ALMOST_MARGIN(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [15:0] din);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 16'h0);
        step();
        rst_n = 1'b1;
        step();

        // Reset then idle
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        check("rst_half", 32'(bus.half_full), 32'd0);
        check("rst_aempty", 32'(bus.almostempty), 32'd0);
        check("rst_afull", 32'(bus.almostfull), 32'd0);
        check("rst_dout", 32'(bus.data_out), 32'h0);
        check("rst_ack", 32'(bus.wr_ack), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_udf", 32'(bus.underflow), 32'd0);

        // Read while empty
        drive(1'b0, 1'b1, 16'h0);
        step();
        drive(1'b0, 1'b0, 16'h0);
        check("udf_pulse", 32'(bus.underflow), 32'd1);
        check("udf_dout", 32'(bus.data_out), 32'h0);
        check("udf_empty", 32'(bus.empty), 32'd1);
        step();
        check("udf_clear", 32'(bus.underflow), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            step();
            check("fill_ack", 32'(bus.wr_ack), 32'd1);
            check("fill_half", 32'(bus.half_full), 32'(i >= 4));
            check("fill_afull", 32'(bus.almostfull), 32'(i == 7));
            check("fill_full", 32'(bus.full), 32'(i == 8));
        end
        drive(1'b1, 1'b0, 16'hDEAD);
        step();
        check("ovf_pulse", 32'(bus.overflow), 32'd1);
        check("ovf_ack", 32'(bus.wr_ack), 32'd0);
        check("ovf_full", 32'(bus.full), 32'd1);
        drive(1'b0, 1'b0, 16'h0);
        step();
        check("ovf_clear", 32'(bus.overflow), 32'd0);

        // Drain in order, then one entry across the wrapped pointers
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            step();
            check("drain_dout", 32'(bus.data_out), 32'(i));
            check("drain_aempty", 32'(bus.almostempty), 32'(i == 7));
            check("drain_empty", 32'(bus.empty), 32'(i == 8));
        end
        drive(1'b1, 1'b0, 16'h00AA);
        step();
        check("wrap_ack", 32'(bus.wr_ack), 32'd1);
        drive(1'b0, 1'b1, 16'h0);
        step();
        check("wrap_dout", 32'(bus.data_out), 32'h00AA);
        check("wrap_empty", 32'(bus.empty), 32'd1);

        // Simultaneous request with count==3
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 1'b0, 16'(i * 16'h11));
            step();
        end
        drive(1'b1, 1'b1, 16'h0055);
        step();
        check("rw3_ack", 32'(bus.wr_ack), 32'd1);
        check("rw3_udf", 32'(bus.underflow), 32'd0);
        check("rw3_dout", 32'(bus.data_out), 32'h0011);
        check("rw3_empty", 32'(bus.empty), 32'd0);
        drive(1'b0, 1'b1, 16'h0);
        step();
        check("rw3_d1", 32'(bus.data_out), 32'h0022);
        step();
        check("rw3_d2", 32'(bus.data_out), 32'h0033);
        check("rw3_ae", 32'(bus.almostempty), 32'd1);
        step();
        check("rw3_d3", 32'(bus.data_out), 32'h0055);
        check("rw3_empty_end", 32'(bus.empty), 32'd1);

        // Simultaneous request while empty: write wins, no read-through
        drive(1'b1, 1'b1, 16'h0077);
        step();
        check("rw0_ack", 32'(bus.wr_ack), 32'd1);
        check("rw0_udf", 32'(bus.underflow), 32'd1);
        check("rw0_dout", 32'(bus.data_out), 32'h0055);
        check("rw0_ae", 32'(bus.almostempty), 32'd1);
        drive(1'b0, 1'b1, 16'h0);
        step();
        check("rw0_read", 32'(bus.data_out), 32'h0077);
        check("rw0_empty", 32'(bus.empty), 32'd1);

        // Simultaneous request while full
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'(16'h0100 + i));
            step();
        end
        check("rw8_pre_full", 32'(bus.full), 32'd1);
        drive(1'b1, 1'b1, 16'hBEEF);
        step();
        drive(1'b0, 1'b0, 16'h0);
        check("rw8_dout", 32'(bus.data_out), 32'h0100);
`ifdef FIFO_FULL_RW_EN
        check("rw8_ack", 32'(bus.wr_ack), 32'd1);
        check("rw8_ovf", 32'(bus.overflow), 32'd0);
        check("rw8_full", 32'(bus.full), 32'd1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            step();
            check("rw8_drain", 32'(bus.data_out), 32'(16'h0100 + i));
        end
        step();
        check("rw8_last", 32'(bus.data_out), 32'hBEEF);
`else
        check("rw8_ack", 32'(bus.wr_ack), 32'd0);
        check("rw8_ovf", 32'(bus.overflow), 32'd1);
        check("rw8_full", 32'(bus.full), 32'd0);
        check("rw8_afull", 32'(bus.almostfull), 32'd1);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            step();
            check("rw8_drain", 32'(bus.data_out), 32'(16'h0100 + i));
        end
`endif
        check("rw8_empty", 32'(bus.empty), 32'd1);
        drive(1'b0, 1'b0, 16'h0);
        step();

        // Reset alongside a write at count==5
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 16'(16'h0200 + i));
            step();
        end
        check("pre_rst_half", 32'(bus.half_full), 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 16'h0999);
        step();
        check("rstw_ack", 32'(bus.wr_ack), 32'd0);
        check("rstw_ovf", 32'(bus.overflow), 32'd0);
        check("rstw_empty", 32'(bus.empty), 32'd1);
        check("rstw_half", 32'(bus.half_full), 32'd0);
        check("rstw_dout", 32'(bus.data_out), 32'h0);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 16'h0);
        step();
        drive(1'b0, 1'b0, 16'h0);
        check("post_rst_ack", 32'(bus.wr_ack), 32'd0);
        check("post_rst_udf", 32'(bus.underflow), 32'd1);
        check("post_rst_dout", 32'(bus.data_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
